// File: rtl/bootrom_responder_pkg.sv
// bootrom_responder_pkg: shared response causes, window config and boot ROM contents.
package bootrom_responder_pkg;
  typedef enum logic [1:0] {CAUSE_OK, CAUSE_RANGE, CAUSE_WRITE, CAUSE_MISALIGN} rsp_cause_e;
  typedef struct packed {
    logic [31:0] base;
    logic [31:0] range;
  } config_t;
  localparam config_t DEFAULT_CFG = '{base: 32'h8000_0000, range: 32'h0000_1000};
  localparam logic [31:0] BOOT_WORD0 = 32'h0000_0297;
  // Word 0 is the boot instruction; the rest carry a tag plus their own index.
  function automatic logic [31:0] rom_word(input logic [31:0] i);
    return i == 32'd0 ? BOOT_WORD0 : {16'hB007, i[15:0]};
  endfunction
endpackage

// File: rtl/bootrom_responder_if.sv
// bootrom_responder_if: valid/ready request/response bus between initiator and boot ROM responder.
interface bootrom_responder_if import bootrom_responder_pkg::*; #(parameter int XLEN = 32);
  logic req_valid;
  logic req_ready;
  logic [XLEN-1:0] req_addr;
  logic req_we;
  logic rsp_valid;
  logic rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic rsp_err;
  rsp_cause_e rsp_cause;
  modport master (output req_valid, req_addr, req_we, rsp_ready,
                  input req_ready, rsp_valid, rsp_data, rsp_err, rsp_cause);
  modport slave (input req_valid, req_addr, req_we, rsp_ready,
                 output req_ready, rsp_valid, rsp_data, rsp_err, rsp_cause);
endinterface

// File: rtl/bootrom_responder_rom.sv
// rom1p1r: single-port synchronous-read ROM holding the boot image.
module rom1p1r import bootrom_responder_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter bit PRELOAD_ENABLED = 1'b1
) (
  input  logic clk,
  input  logic ce_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] rdata_q;
  always_ff @(posedge clk)
    if (ce_i) rdata_q <= PRELOAD_ENABLED ? DATA_WIDTH'(rom_word(32'(addr_i))) : '0;
  assign rdata_o = rdata_q;
endmodule

// File: rtl/bootrom_responder.sv
// bootrom_responder: decodes bus requests against the boot ROM window and returns data or a fault.
module bootrom_responder import bootrom_responder_pkg::*; #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] BASE = 32'h8000_0000,
  parameter logic [XLEN-1:0] RANGE = 32'h0000_1000,
  parameter bit PRELOAD_ENABLED = 1'b1
) (
  input logic clk,
  input logic rst_n,
  bootrom_responder_if.slave bus
);
  localparam int OFS = $clog2(XLEN/8);
  localparam int DEPTH = int'(RANGE) / (XLEN/8);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, READ, RESP} state_e;
  state_e state_q;
  logic rsp_valid_q, rsp_err_q;
  logic [XLEN-1:0] rsp_data_q, rom_data, off;
  rsp_cause_e rsp_cause_q, cause;
  logic [XLEN:0] addr_x, base_x;
  logic oor, mis, accept, hit;
  // One extra bit keeps BASE+RANGE from wrapping at the top of the address space.
  assign addr_x = {1'b0, bus.req_addr};
  assign base_x = {1'b0, BASE};
  assign oor = addr_x < base_x || addr_x >= base_x + {1'b0, RANGE};
  assign mis = |bus.req_addr[OFS-1:0];
  assign cause = oor ? CAUSE_RANGE : bus.req_we ? CAUSE_WRITE : mis ? CAUSE_MISALIGN : CAUSE_OK;
  assign hit = cause == CAUSE_OK;
  assign accept = state_q == IDLE && bus.req_valid;
  assign off = bus.req_addr - BASE;
  rom1p1r #(.DATA_WIDTH(XLEN), .DEPTH(DEPTH), .PRELOAD_ENABLED(PRELOAD_ENABLED)) u_rom (
    .clk,
    .ce_i(accept && hit),
    .addr_i(AW'(off >> OFS)),
    .rdata_o(rom_data)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
      rsp_cause_q <= CAUSE_OK;
    end else
      case (state_q)
        IDLE: if (bus.req_valid) begin
          state_q <= hit ? READ : RESP;
          rsp_valid_q <= !hit;
          rsp_data_q <= '0;
          rsp_err_q <= !hit;
          rsp_cause_q <= cause;
        end
        READ: begin
          state_q <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_data_q <= rom_data;
        end
        RESP: if (bus.rsp_ready) begin
          state_q <= IDLE;
          rsp_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data = rsp_data_q;
  assign bus.rsp_err = rsp_err_q;
  assign bus.rsp_cause = rsp_cause_q;
endmodule

// File: tb/tb_bootrom_responder.sv
// tb_bootrom_responder: directed vector table plus handshake, streaming and async-reset sequences.
module tb_bootrom_responder;
  logic clk, rst_n;
  int checks, errors, cyc;
  bootrom_responder_if #(.XLEN(32)) bus();
  bootrom_responder #(.XLEN(32), .BASE(32'h8000_0000), .RANGE(32'h0000_1000), .PRELOAD_ENABLED(1'b1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  typedef struct {
    logic [31:0] addr;
    logic we;
    logic err;
    logic [1:0] cause;
    logic [31:0] data;
    int lat;
  } vec_t;
  vec_t v[12];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not end, required completion");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] img(input int i);
    logic [15:0] lo;
    lo = 16'(i);
    return i == 0 ? 32'h0000_0297 : {16'hB007, lo};
  endfunction
  task automatic do_req(input logic [31:0] addr, input logic we, output logic [31:0] data,
                        output logic err, output logic [1:0] cause, output int lat);
    bus.req_valid = 1'b1;
    bus.req_addr = addr;
    bus.req_we = we;
    chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    data = bus.rsp_data;
    err = bus.rsp_err;
    cause = bus.rsp_cause;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask
  initial begin
    logic [31:0] d, bp_data;
    logic e;
    logic [1:0] c;
    int lat, c0;
    checks = 0;
    errors = 0;
    cyc = 0;
    v[0]  = '{32'h8000_0000, 1'b0, 1'b0, 2'd0, 32'h0000_0297, 2};
    v[1]  = '{32'h8000_0FFC, 1'b0, 1'b0, 2'd0, 32'hB007_03FF, 2};
    v[2]  = '{32'h8000_1000, 1'b0, 1'b1, 2'd1, 32'h0, 1};
    v[3]  = '{32'h7FFF_FFFC, 1'b0, 1'b1, 2'd1, 32'h0, 1};
    v[4]  = '{32'h8000_0002, 1'b1, 1'b1, 2'd2, 32'h0, 1};
    v[5]  = '{32'h8000_0002, 1'b0, 1'b1, 2'd3, 32'h0, 1};
    v[6]  = '{32'h9000_0001, 1'b1, 1'b1, 2'd1, 32'h0, 1};
    v[7]  = '{32'h8000_0004, 1'b0, 1'b0, 2'd0, 32'hB007_0001, 2};
    v[8]  = '{32'h8000_0010, 1'b1, 1'b1, 2'd2, 32'h0, 1};
    v[9]  = '{32'hFFFF_FFFC, 1'b0, 1'b1, 2'd1, 32'h0, 1};
    v[10] = '{32'h0000_0000, 1'b0, 1'b1, 2'd1, 32'h0, 1};
    v[11] = '{32'h8000_0801, 1'b0, 1'b1, 2'd3, 32'h0, 1};
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.req_we = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_data", bus.rsp_data, 32'd0);
    chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("reset_rsp_cause", 32'(bus.rsp_cause), 32'd0);
    rst_n = 1'b1;
    #1 chk("reset_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      do_req(v[i].addr, v[i].we, d, e, c, lat);
      chk($sformatf("vec%0d_data", i), d, v[i].data);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(v[i].err));
      chk($sformatf("vec%0d_cause", i), 32'(c), 32'(v[i].cause));
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(v[i].lat));
    end
    // Backpressure: response held while a competing request waits.
    bus.req_valid = 1'b1;
    bus.req_addr = 32'h8000_0008;
    bus.req_we = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", 32'(lat), 32'd2);
    bp_data = 32'hB007_0002;
    bus.req_valid = 1'b1;
    bus.req_addr = 32'h8000_1000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rsp_data", bus.rsp_data, bp_data);
      chk("bp_rsp_err_cause", {30'd0, bus.rsp_err, 1'b0} | 32'(bus.rsp_cause), 32'd0);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("bp_release_req_ready", 32'(bus.req_ready), 32'd1);
    chk("bp_release_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk("bp_no_stray_accept", 32'(bus.rsp_valid), 32'd0);
    // Streaming: 16 sequential reads, three cycles each.
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      do_req(32'h8000_0000 + 32'(4 * i), 1'b0, d, e, c, lat);
      chk($sformatf("stream%0d_data", i), d, img(i));
      chk($sformatf("stream%0d_err", i), 32'(e), 32'd0);
    end
    chk("stream_cycles", 32'(cyc - c0), 32'd48);
    // Async reset while READ is in flight.
    bus.req_valid = 1'b1;
    bus.req_addr = 32'h8000_0000;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("read_state_req_ready", 32'(bus.req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1 chk("rst_read_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_read_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_read_no_stale", 32'(bus.rsp_valid), 32'd0);
    end
    // Async reset while a response is pending.
    bus.req_valid = 1'b1;
    bus.req_addr = 32'h8000_0FFC;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("resp_pre_valid", 32'(bus.rsp_valid), 32'd1);
    chk("resp_pre_data", bus.rsp_data, 32'hB007_03FF);
    #2 rst_n = 1'b0;
    #1 chk("rst_resp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_resp_data", bus.rsp_data, 32'd0);
    chk("rst_resp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_resp_cause", 32'(bus.rsp_cause), 32'd0);
    chk("rst_resp_req_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_resp_no_stale", 32'(bus.rsp_valid), 32'd0);
    end
    do_req(32'h8000_0000, 1'b0, d, e, c, lat);
    chk("recover_data", d, 32'h0000_0297);
    chk("recover_latency", 32'(lat), 32'd2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
